fetch_queue: RTL and testbench

Parametrised instruction fetch unit that replaces the fixed single-entry fetch stage. It talks to instruction memory through a request/grant/response handshake that tolerates variable latency. It keeps up to DEPTH fetches in flight or buffered, and drives the IF/ID pipeline register with a valid bit. Stall, flush and redirect requests come from the hazard unit; decode consumes the outputs unchanged.

---
 rtl/fetch_queue.sv | 102 ++++++++++
 tb/tb_fetch_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: credit-limited requests to a variable-latency
// instruction memory, an in-order response FIFO, and the IF/ID pipeline register.
module fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] NOP        = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            IMEM_req_o,
  output logic [XLEN-1:0] IMEM_addr_o,
  input  logic            IMEM_gnt_i,
  input  logic            IMEM_rvalid_i,
  input  logic [XLEN-1:0] IMEM_data_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            PIP_valid_o,
  output logic [XLEN-1:0] PIP_instruction_o,
  output logic [XLEN-1:0] PIP_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]   ONE     = CW'(1);
  localparam logic [CW-1:0]   ZERO    = '0;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, live, drop;
  logic [CW:0]     credit_sum;
  logic            grant, resp_drop, resp_keep, push, pop;

  // Every queued entry and every outstanding request holds one credit, so a
  // response always has a FIFO slot waiting for it.
  assign credit_sum  = {1'b0, count} + {1'b0, live} + {1'b0, drop};
  assign IMEM_req_o  = reset_n & ~flush_i & (credit_sum < DEPTH_C);
  assign IMEM_addr_o = fetch_pc;

  assign grant     = IMEM_req_o & IMEM_gnt_i;
  assign resp_drop = IMEM_rvalid_i & (drop != ZERO);
  assign resp_keep = IMEM_rvalid_i & (drop == ZERO) & (live != ZERO);
  assign push      = resp_keep & ~flush_i;
  assign pop       = ~flush_i & ~stall_i & (count != ZERO);

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= IMEM_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc          <= RESET_ADDR;
      resp_pc           <= RESET_ADDR;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= ZERO;
      live              <= ZERO;
      drop              <= ZERO;
      PIP_valid_o       <= 1'b0;
      PIP_instruction_o <= NOP;
      PIP_pc_o          <= '0;
    end else if (flush_i) begin
      // Outstanding live requests become drops; a response landing now retires one of them.
      fetch_pc          <= redirect_addr_i;
      resp_pc           <= redirect_addr_i;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= ZERO;
      live              <= ZERO;
      drop              <= drop + live - ((resp_drop | resp_keep) ? ONE : ZERO);
      PIP_valid_o       <= 1'b0;
      PIP_instruction_o <= NOP;
    end else begin
      if (grant)     fetch_pc <= fetch_pc + STEP;
      if (resp_keep) resp_pc  <= resp_pc + STEP;
      if (resp_drop) drop     <= drop - ONE;
      if (push)      wr_ptr   <= wr_ptr + 1'b1;
      if (pop)       rd_ptr   <= rd_ptr + 1'b1;
      live  <= live + (grant ? ONE : ZERO) - (resp_keep ? ONE : ZERO);
      count <= count + (push ? ONE : ZERO) - (pop ? ONE : ZERO);
      if (!stall_i) begin
        if (pop) begin
          PIP_valid_o       <= 1'b1;
          PIP_instruction_o <= instr_mem[rd_ptr];
          PIP_pc_o          <= pc_mem[rd_ptr];
        end else begin
          PIP_valid_o       <= 1'b0;
          PIP_instruction_o <= NOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed per-cycle vectors for streaming and
// stall, plus hand-written sequences for credit exhaustion, flush and reset.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'hA5C3_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect;
  logic        pvalid;
  logic [31:0] pinstr;
  logic [31:0] ppc;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_ADDR(32'h0), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .IMEM_req_o(req), .IMEM_addr_o(addr), .IMEM_gnt_i(gnt),
    .IMEM_rvalid_i(rvalid), .IMEM_data_i(rdata),
    .stall_i(stall), .flush_i(flush), .redirect_addr_i(redirect),
    .PIP_valid_o(pvalid), .PIP_instruction_o(pinstr), .PIP_pc_o(ppc)
  );

  typedef struct packed {
    logic [31:0] addr;
    int          gcyc;
  } pend_t;

  typedef struct packed {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t pending[$];
  vec_t  vecs[20];
  int    cyc = 0;
  int    lat = 1;
  logic  hold = 1'b1;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] a,
                              input logic v, input logic [31:0] p);
    vec_t t;
    t.stall = s; t.exp_req = r; t.exp_addr = a; t.exp_valid = v; t.exp_pc = p;
    return t;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // In-order memory model: answers each grant once it is lat cycles old, unless held.
  task automatic driveMem();
    if (!hold && pending.size() > 0 && cyc >= pending[0].gcyc + lat) begin
      rvalid = 1'b1;
      rdata  = dataOf(pending[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] rd,
                               input logic g, input logic h);
    stall = s; flush = f; redirect = rd; gnt = g; hold = h;
    driveMem();
    #1;
  endtask

  task automatic tick();
    logic        g_now, r_now, rst_now;
    logic [31:0] a_now;
    g_now = req & gnt; a_now = addr; r_now = rvalid; rst_now = reset_n;
    @(posedge clk);
    if (!rst_now) pending.delete();
    else begin
      if (r_now) void'(pending.pop_front());
      if (g_now) pending.push_back(pend_t'{addr: a_now, gcyc: cyc});
    end
    cyc++;
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, "_req"},   {31'b0, req},    {31'b0, v.exp_req});
    checkVal({tag, "_addr"},  addr,            v.exp_addr);
    checkVal({tag, "_valid"}, {31'b0, pvalid}, {31'b0, v.exp_valid});
    checkVal({tag, "_pc"},    ppc,             v.exp_pc);
    checkVal({tag, "_instr"}, pinstr,          v.exp_valid ? dataOf(v.exp_pc) : NOP);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkVal("rst_req_low", {31'b0, req}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          nvalid;
    logic [31:0] exp_pc;

    // stall, req, addr, valid, pc: streaming, then stall held for cycles 6..10
    vecs[0]  = mk(0, 1, 32'h00, 0, 32'h00);
    vecs[1]  = mk(0, 1, 32'h04, 0, 32'h00);
    vecs[2]  = mk(0, 1, 32'h08, 0, 32'h00);
    vecs[3]  = mk(0, 1, 32'h0C, 1, 32'h00);
    vecs[4]  = mk(0, 1, 32'h10, 1, 32'h04);
    vecs[5]  = mk(0, 1, 32'h14, 1, 32'h08);
    vecs[6]  = mk(1, 1, 32'h18, 1, 32'h0C);
    vecs[7]  = mk(1, 1, 32'h1C, 1, 32'h0C);
    vecs[8]  = mk(1, 0, 32'h20, 1, 32'h0C);
    vecs[9]  = mk(1, 0, 32'h20, 1, 32'h0C);
    vecs[10] = mk(1, 0, 32'h20, 1, 32'h0C);
    vecs[11] = mk(0, 0, 32'h20, 1, 32'h0C);
    vecs[12] = mk(0, 1, 32'h20, 1, 32'h10);
    vecs[13] = mk(0, 1, 32'h24, 1, 32'h14);
    vecs[14] = mk(0, 1, 32'h28, 1, 32'h18);
    vecs[15] = mk(0, 1, 32'h2C, 1, 32'h1C);
    vecs[16] = mk(0, 1, 32'h30, 1, 32'h20);
    vecs[17] = mk(0, 1, 32'h34, 1, 32'h24);
    vecs[18] = mk(0, 1, 32'h38, 1, 32'h28);
    vecs[19] = mk(0, 1, 32'h3C, 1, 32'h2C);

    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 32'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;

    // Streaming with 1-cycle latency, then a 5-cycle stall
    doReset();
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("stream", vecs[i]);
      tick();
    end

    // Responses withheld: exactly four grants, then the FIFO fills under stall
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkVal("credit_req", {31'b0, req}, (i < 4) ? 32'd1 : 32'd0);
      checkVal("credit_addr", addr, 32'(4 * i));
      tick();
    end
    for (int i = 5; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      checkVal("credit_hold_req", {31'b0, req}, 32'd0);
      tick();
    end
    for (int i = 7; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      checkVal("fill_req", {31'b0, req}, 32'd0);
      checkVal("fill_valid", {31'b0, pvalid}, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("full_req", {31'b0, req}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("resume_req", {31'b0, req}, 32'd1);
    checkVal("resume_addr", addr, 32'h10);
    checkVal("resume_valid", {31'b0, pvalid}, 32'd1);
    checkVal("resume_pc", ppc, 32'h0);
    checkVal("resume_instr", pinstr, dataOf(32'h0));
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("resume_pc2", ppc, 32'h4);
    tick();

    // Flush with three requests in flight
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkVal("inflight_addr", addr, 32'(4 * i));
      tick();
    end
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
    checkVal("flush_req", {31'b0, req}, 32'd0);
    tick();
    nvalid = 0;
    exp_pc = 32'h100;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 0) begin
        checkVal("redir_req", {31'b0, req}, 32'd1);
        checkVal("redir_addr", addr, 32'h100);
      end
      if (pvalid) begin
        checkVal("redir_pc", ppc, exp_pc);
        checkVal("redir_instr", pinstr, dataOf(exp_pc));
        exp_pc += 32'h4;
        nvalid++;
      end
      tick();
    end
    checkVal("redir_count_ok", (nvalid >= 15) ? 32'd1 : 32'd0, 32'd1);

    // Flush together with stall and an arriving response
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0); tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b0);
    checkVal("fs_pre_valid", {31'b0, pvalid}, 32'd1);
    checkVal("fs_pre_pc", ppc, 32'h0);
    checkVal("fs_req", {31'b0, req}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("fs_bubble_valid", {31'b0, pvalid}, 32'd0);
    checkVal("fs_bubble_instr", pinstr, NOP);
    checkVal("fs_bubble_pc", ppc, 32'h0);
    checkVal("fs_redir_req", {31'b0, req}, 32'd1);
    checkVal("fs_redir_addr", addr, 32'h200);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkVal("fs_wait_valid", {31'b0, pvalid}, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("fs_first_valid", {31'b0, pvalid}, 32'd1);
    checkVal("fs_first_pc", ppc, 32'h200);
    checkVal("fs_first_instr", pinstr, dataOf(32'h200));
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("fs_second_pc", ppc, 32'h204);
    checkVal("fs_second_instr", pinstr, dataOf(32'h204));
    tick();

    // Reset pulse with a full FIFO
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i >= 6) ? 1'b1 : 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("rp_req_low", {31'b0, req}, 32'd0);
    checkVal("rp_pre_pc", ppc, 32'h0C);
    tick();
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkVal("rp_valid", {31'b0, pvalid}, 32'd0);
    checkVal("rp_instr", pinstr, NOP);
    checkVal("rp_pc", ppc, 32'h0);
    checkVal("rp_restart_req", {31'b0, req}, 32'd1);
    checkVal("rp_restart_addr", addr, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkVal("rp_wait_valid", {31'b0, pvalid}, 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkVal("rp_out_valid", {31'b0, pvalid}, 32'd1);
      checkVal("rp_out_pc", ppc, 32'(4 * i));
      checkVal("rp_out_instr", pinstr, dataOf(32'(4 * i)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
